// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// Used by uart_rx_16x (parity state enabled by UART_RX_PARITY_EN) and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   localparam logic [3:0] SAMPLE_MID  = 4'd7;
   localparam logic [3:0] SAMPLE_LAST = 4'd15;
   localparam int         OVERSAMPLE  = 16;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage bit synchronizer for asynchronous inputs; resets to the idle-high level.
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_r;

   // Shift chain, oldest sample at the MSB
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= '1;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx_16x.sv
// 16x-oversampling UART receiver with registered word, valid strobe and error pulses.
// Optional parity bit handling is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_16x
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int PARITY_ODD  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en_16_x_baud,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 framing_error,
   output logic                 parity_error,
   output logic                 busy
);

   localparam logic [3:0] BIT_END = 4'(DATA_BITS);

   logic                 rx_s;
   rx_state_t            state_r, state_n;
   logic [3:0]           tick_r, tick_n;
   logic [3:0]           bit_r, bit_n;
   logic [DATA_BITS-1:0] shift_r, shift_n;
   logic [DATA_BITS-1:0] dout_r, dout_n;
   logic                 valid_r, valid_n;
   logic                 ferr_r, ferr_n;
   logic                 perr_r, perr_n;
   logic                 busy_r, busy_n;
`ifdef UART_RX_PARITY_EN
   localparam logic PAR_SENSE = 1'(PARITY_ODD);
   logic par_r, par_n;

   function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
      return (^d) ^ p ^ PAR_SENSE;
   endfunction
`endif

   uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (serial_in),
      .q     (rx_s)
   );

   // Next-state, bit timing and frame assembly
   always_comb begin
      state_n = state_r;
      tick_n  = tick_r;
      bit_n   = bit_r;
      shift_n = shift_r;
      dout_n  = dout_r;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      perr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_n   = par_r;
`endif
      if (en_16_x_baud) begin
         tick_n = tick_r + 4'd1;
         case (state_r)
            IDLE: begin
               if (!rx_s) begin
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
            START: begin
               if (tick_r == SAMPLE_MID) begin
                  if (rx_s) begin
                     state_n = IDLE;
                  end else begin
                     state_n = DATA;
                     bit_n   = 4'd0;
                  end
               end else begin
                  state_n = START;
               end
            end
            DATA: begin
               if (tick_r == SAMPLE_LAST) begin
                  shift_n = {rx_s, shift_r[DATA_BITS-1:1]};
                  bit_n   = bit_r + 4'd1;
                  if (bit_n == BIT_END) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end else begin
                     state_n = DATA;
                  end
               end else begin
                  state_n = DATA;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick_r == SAMPLE_LAST) begin
                  par_n   = rx_s;
                  state_n = STOP;
               end else begin
                  state_n = PARITY;
               end
            end
`endif
            STOP: begin
               if (tick_r == SAMPLE_LAST) begin
                  dout_n  = shift_r;
                  valid_n = 1'b1;
                  ferr_n  = !rx_s;
`ifdef UART_RX_PARITY_EN
                  perr_n  = parity_mismatch(shift_r, par_r);
`endif
                  if (rx_s) begin
                     state_n = IDLE;
                  end else begin
                     state_n = BREAK;
                  end
               end else begin
                  state_n = STOP;
               end
            end
            // A held-low line parks here until it returns high
            BREAK: begin
               if (rx_s) begin
                  state_n = IDLE;
               end else begin
                  state_n = BREAK;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
         if (state_n != state_r) begin
            tick_n = 4'd0;
         end else begin
            tick_n = tick_n;
         end
      end else begin
         tick_n = tick_r;
      end
      busy_n = (state_n != IDLE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         tick_r  <= 4'd0;
         bit_r   <= 4'd0;
         shift_r <= '0;
         dout_r  <= '0;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         perr_r  <= 1'b0;
         busy_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_n;
         tick_r  <= tick_n;
         bit_r   <= bit_n;
         shift_r <= shift_n;
         dout_r  <= dout_n;
         valid_r <= valid_n;
         ferr_r  <= ferr_n;
         perr_r  <= perr_n;
         busy_r  <= busy_n;
`ifdef UART_RX_PARITY_EN
         par_r   <= par_n;
`endif
      end
   end

   assign data_out      = dout_r;
   assign data_valid    = valid_r;
   assign framing_error = ferr_r;
   assign parity_error  = perr_r;
   assign busy          = busy_r;

endmodule

// File: doc/uart_rx_16x.md
Name: uart_rx_16x

Overview:
Asynchronous serial receiver that uses the 16x-baud enable strobe from the baud generator. It oversamples the line, qualifies the start bit at mid-bit and samples each data bit at its centre. Each frame is delivered as a parallel word with a one-cycle valid strobe and error flags. It sits between the board RX pin and the PicoBlaze input port / RX FIFO.

Parameters:
DATA_BITS, 8, number of data bits per frame, LSB first (5..9)
SYNC_STAGES, 2, flip-flops in the serial_in synchronizer (>=2)
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en_16_x_baud  input  1  one-clk-wide strobe at 16x baud rate; all bit timing advances only on cycles where it is 1
serial_in  input  1  raw RX line, idle high, asynchronous to clk
data_out  output  DATA_BITS  last received word; held until the next frame completes
data_valid  output  1  one-clk pulse when data_out updates
framing_error  output  1  one-clk pulse, coincident with data_valid, when the stop bit is sampled 0
parity_error  output  1  one-clk pulse, coincident with data_valid, on parity mismatch (constant 0 without the macro)
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, immediate): synchronizer flops = 1, state = IDLE, tick_cnt = 0, bit_cnt = 0, shift register = 0. data_out = 0; data_valid, framing_error, parity_error and busy = 0. Reset mid-frame aborts the frame silently.
- rx_s = serial_in after SYNC_STAGES flops.
- tick_cnt is 4 bits and advances only on en_16_x_baud. It clears on every state transition and wraps 15->0.
- IDLE: on an en tick with rx_s = 0, go to START with tick_cnt = 0.
- START: on the tick where tick_cnt == 7 (mid start bit), sample rx_s.
  - If 1: glitch; return to IDLE with no output.
  - If 0: go to DATA with tick_cnt = 0 and bit_cnt = 0.
- DATA: on the tick where tick_cnt == 15, sample rx_s.
  - Shift right, inserting the sample at the MSB (LSB-first line order).
  - bit_cnt++. When bit_cnt reaches DATA_BITS, go to PARITY (macro defined) or STOP.
- PARITY (macro only): on tick 15, capture the parity bit, then go to STOP.
- STOP: on tick 15, sample the stop bit. On the next clk edge:
  - data_out <= shift register; data_valid = 1 for exactly one clk.
  - framing_error = !stop_sample; parity_error per the macro rules.
  - If stop_sample = 1, go to IDLE. If stop_sample = 0, go to BREAK.
- BREAK: wait for an en tick with rx_s = 1, then go to IDLE. This prevents a line held low (break) from being decoded as repeated 0x00 frames.
- Latency: data_valid asserts 1 clk after the mid-stop-bit en tick, i.e. ~(1 + DATA_BITS + 0.5) bit times (plus one more with parity) after the start edge, plus SYNC_STAGES clks.
- Back-to-back frames: the FSM is in IDLE from the clk after mid-stop. A start edge arriving during the second half of the stop bit must be detected.
- serial_in changes while en_16_x_baud = 0 have no effect until the next tick.
- en_16_x_baud held permanently high is legal (bit = 16 clks) and is used by the fast bench.

Optional Feature:
UART_RX_PARITY_EN
- Defined: the PARITY state is present. The received parity bit is compared with the XOR of the data bits; an odd total ones count (including the parity bit) is a match when PARITY_ODD = 1, an even total when PARITY_ODD = 0. parity_error pulses with data_valid on mismatch.
- Not defined: no PARITY state; parity_error is tied to 0; frame = start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg:
  - rx state encoding: IDLE, START, DATA, PARITY, STOP, BREAK
  - localparams SAMPLE_MID = 4'd7, SAMPLE_LAST = 4'd15, OVERSAMPLE = 16
  - Shared with the future transmitter.
- One sub-module: uart_sync (SYNC_STAGES-deep bit synchronizer, reset value 1), reused by the transmitter's CTS input.

Test Plan:
1. 50 MHz clk, real baud generator at 115200. Send 0x55 (8N1) -> data_out = 0x55, data_valid high exactly 1 clk, framing_error = 0, busy falls the same cycle.
2. serial_in low for 4 en ticks then high -> no data_valid; FSM back in IDLE (busy = 0) by tick 8.
3. Send 0xA3 with stop bit = 0, then hold low for 3 bit times -> one data_valid with data_out = 0xA3 and framing_error = 1; no further frames until the line goes high; next 0x0F frame is received cleanly.
4. en tied high. Send 0x00 then 0xFF with zero idle between -> two data_valid pulses, 0x00 then 0xFF, no errors.
5. Assert reset during data bit 4 of 0x3C -> all outputs 0 in the same cycle. Release, send 0x3C -> received correctly.
6. UART_RX_PARITY_EN defined, PARITY_ODD = 0. Send 0x07 with parity bit 0 -> data_out = 0x07, parity_error = 1. Send 0x07 with parity bit 1 -> parity_error = 0.
